mem_stage: RTL

- Memory stage of the pipeline: the consumer of the execute stage's EX/MEM buffer.
- Takes the ALU result, store data and control bits, and performs data-memory reads/writes over a req/ready handshake with variable latency.
- Stalls upstream stages while a memory access is outstanding.
- Registers the write-back result into the MEM/WB buffer and drives the forwarding value back toward execute (the source for Fa/Fb selection).

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_wb_buffer.sv | 20 ++
 rtl/mem_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM states, the MEM/WB record reused by
// write-back, and the forwarding-select encoding shared with execute.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rc;
        logic              regWrite;
    } memwb_t;

    // Fa/Fb operand-select encoding used by the execute stage muxes.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    function automatic logic isMemOp(input logic store, input logic load);
        return store || load;
    endfunction

endpackage

// File: rtl/mem_wb_buffer.sv
// MEM/WB pipeline register: synchronous reset, load when enabled.
module mem_wb_buffer
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  memwb_t d,
    output memwb_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory accesses over a req/ready handshake,
// stalls upstream while one is outstanding, and fills the MEM/WB buffer.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int N    = DATA_W,
    parameter int REGW = REG_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    aluOut,
    input  logic [N-1:0]    rd3,
    input  logic [REGW-1:0] Rc,
    input  logic            memWrite,
    input  logic            memToReg,
    input  logic            regWrite,
    input  logic            inValid,
    output logic            memReq,
    output logic            memWe,
    output logic [N-1:0]    memAddr,
    output logic [N-1:0]    memWData,
    input  logic            memReady,
    input  logic [N-1:0]    memRData,
    output logic            stall,
    output logic [N-1:0]    result,
    output logic [REGW-1:0] RcOut,
    output logic            regWriteOut,
    output logic [N-1:0]    fwdData,
    output logic            fwdValid
);

    state_e          state;
    logic [REGW-1:0] holdRc;
    logic            holdRegWrite;
    logic            issue;
    memwb_t          wbNext;
    memwb_t          wbQ;
    logic            wbLoad;

    assign issue = en && inValid && isMemOp(memWrite, memToReg);

    // The issue cycle stalls too, so the instruction already captured is not
    // re-presented; completion releases stall so the successor advances.
    assign stall = !rst && ((state == IDLE) ? issue : !memReady);

    assign fwdData  = aluOut;
    assign fwdValid = inValid && regWrite && !memToReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddr      <= '0;
            memWData     <= '0;
            holdRc       <= '0;
            holdRegWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state        <= ACCESS;
                        memReq       <= 1'b1;
                        memWe        <= memWrite;
                        memAddr      <= aluOut;
                        memWData     <= rd3;
                        holdRc       <= Rc;
                        holdRegWrite <= regWrite;
                    end
                end
                ACCESS: begin
                    if (memReady) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completing access is recorded even with en low so the response is never lost.
    always_comb begin
        wbNext = wbQ;
        wbLoad = 1'b0;
        if (state == IDLE) begin
            if (en) begin
                wbLoad = 1'b1;
                if (!inValid || issue) begin
                    wbNext.regWrite = 1'b0;
                end else begin
                    wbNext.result   = aluOut;
                    wbNext.rc       = Rc;
                    wbNext.regWrite = regWrite;
                end
            end
        end else if (memReady) begin
            wbLoad = 1'b1;
            if (!memWe) begin
                wbNext.result   = memRData;
                wbNext.rc       = holdRc;
                wbNext.regWrite = holdRegWrite;
            end else begin
                wbNext.regWrite = 1'b0;
            end
        end
    end

    mem_wb_buffer u_memWb (
        .clk (clk),
        .rst (rst),
        .en  (wbLoad),
        .d   (wbNext),
        .q   (wbQ)
    );

    assign result      = wbQ.result;
    assign RcOut       = wbQ.rc;
    assign regWriteOut = wbQ.regWrite;

endmodule
